// File: rtl/clk_div_bank.sv
// clk_div_bank: a bank of independent programmable clock dividers running
// from MegaClk. Each channel produces a registered square wave (high for
// ceil(div/2) cycles, low for floor(div/2) cycles) and a one-cycle tick at
// the start of every period. Divisors can be reprogrammed while a channel
// is running: the new value is held pending and takes over at the next
// period boundary, so a period is never truncated or stretched.

module clk_div_bank #(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter int unsigned RESET_DIV = 100000000,
    parameter int          CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              MegaClk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_err
);

    // Smallest divisor that still gives one high and one low cycle.
    localparam logic [CNT_W-1:0] MIN_DIV   = CNT_W'(2);
    localparam logic [CNT_W-1:0] RST_DIV_V = CNT_W'(RESET_DIV);

    // Per-channel counter, active divisor and pending divisor.
    logic [CNT_W-1:0]  cnt_q     [NUM_CH];
    logic [CNT_W-1:0]  cnt_d     [NUM_CH];
    logic [CNT_W-1:0]  div_q     [NUM_CH];
    logic [CNT_W-1:0]  div_d     [NUM_CH];
    logic [CNT_W-1:0]  pendDiv_q [NUM_CH];
    logic [CNT_W-1:0]  pendDiv_d [NUM_CH];
    logic [NUM_CH-1:0] pendVld_q;
    logic [NUM_CH-1:0] pendVld_d;

    // Registered outputs.
    logic [NUM_CH-1:0] clkOut_q;
    logic [NUM_CH-1:0] clkOut_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] divErr_q;
    logic [NUM_CH-1:0] divErr_d;

    // Decoded write and wrap conditions.
    logic              wrDivLegal;
    logic [NUM_CH-1:0] wrHit;
    logic [NUM_CH-1:0] wrLegal;
    logic [NUM_CH-1:0] atWrap;

    // Length of the high phase: ceil(d/2), so odd divisors favour high.
    function automatic logic [CNT_W-1:0] hiLen(input logic [CNT_W-1:0] d);
        return d - (d >> 1);
    endfunction

    assign wrDivLegal = (wr_div >= MIN_DIV);

    // Decode which channel a write targets; out-of-range channel numbers
    // match nothing and are silently dropped.
    always_comb begin
        wrHit   = '0;
        wrLegal = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wrHit[i]   = wr_en && (wr_ch == CH_W'(i));
            wrLegal[i] = wrHit[i] && wrDivLegal;
        end
    end

    // A channel wraps on the last count of its period; >= keeps the
    // counter bounded even if it were ever above div-1.
    always_comb begin
        atWrap = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            atWrap[i] = (cnt_q[i] >= (div_q[i] - CNT_W'(1)));
        end
    end

    // Next-state logic: disable beats restart, restart beats wrap, and a
    // write landing on a boundary goes straight into the active divisor.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            div_d[i]     = div_q[i];
            pendDiv_d[i] = pendDiv_q[i];
            pendVld_d[i] = pendVld_q[i];
            divErr_d[i]  = divErr_q[i];
            tick_d[i]    = 1'b0;

            if (wrHit[i]) begin
                divErr_d[i] = !wrDivLegal;
            end

            if (!ch_en[i]) begin
                cnt_d[i] = '0;
                if (wrLegal[i]) begin
                    div_d[i]     = wr_div;
                    pendVld_d[i] = 1'b0;
                end else if (pendVld_q[i]) begin
                    div_d[i]     = pendDiv_q[i];
                    pendVld_d[i] = 1'b0;
                end
            end else if (sync_restart || atWrap[i]) begin
                cnt_d[i] = '0;
                if (wrLegal[i]) begin
                    div_d[i] = wr_div;
                end else if (pendVld_q[i]) begin
                    div_d[i] = pendDiv_q[i];
                end
                pendVld_d[i] = 1'b0;
                tick_d[i]    = !sync_restart;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                if (wrLegal[i]) begin
                    pendDiv_d[i] = wr_div;
                    pendVld_d[i] = 1'b1;
                end
            end

            clkOut_d[i] = (cnt_d[i] < hiLen(div_d[i]));
        end
    end

    // State and output registers; reset parks every channel at phase 0
    // with the default divisor and the square wave high.
    always_ff @(posedge MegaClk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= '0;
                div_q[i]     <= RST_DIV_V;
                pendDiv_q[i] <= RST_DIV_V;
            end
            pendVld_q <= '0;
            clkOut_q  <= '1;
            tick_q    <= '0;
            divErr_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= cnt_d[i];
                div_q[i]     <= div_d[i];
                pendDiv_q[i] <= pendDiv_d[i];
            end
            pendVld_q <= pendVld_d;
            clkOut_q  <= clkOut_d;
            tick_q    <= tick_d;
            divErr_q  <= divErr_d;
        end
    end

    assign clk_out = clkOut_q;
    assign tick    = tick_q;
    assign div_err = divErr_q;

endmodule
